// File: rtl/divclk_tick_gen.sv
// -----------------------------------------------------------------------------
// divclk_tick_gen
//
// Consumer end of the divided-clock bus. One tap of divided_clocks is selected,
// brought into the fast clock domain through a two-flop synchronizer, and each
// rising edge of the synchronized tap is turned into a single-cycle tick
// strobe. A postscaler emits one tick every (postscale+1) qualifying edges, and
// a wrapping counter records how many ticks have been emitted. Downstream logic
// uses tick as a clock enable and is never clocked from a divided clock.
//
// Ports
//   clock          in   system clock, all logic on its rising edge
//   reset_n        in   asynchronous active-low reset
//   enable         in   1 = generate ticks, 0 = return to IDLE
//   tap_sel        in   index of the divided_clocks bit to follow
//   divided_clocks in   divided-clock bus from the clock divider
//   postscale      in   tick every (postscale+1) tap rising edges
//   tick           out  one-clock strobe (registered)
//   armed          out  1 while in RUN (registered)
//   tick_count     out  ticks since reset or since leaving IDLE, wraps
// -----------------------------------------------------------------------------
module divclk_tick_gen #(
    parameter int N_CLOCKS = 32,
    parameter int SEL_W    = 5,
    parameter int PS_W     = 8,
    parameter int CNT_W    = 16
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                enable,
    input  logic [SEL_W-1:0]    tap_sel,
    input  logic [N_CLOCKS-1:0] divided_clocks,
    input  logic [PS_W-1:0]     postscale,
    output logic                tick,
    output logic                armed,
    output logic [CNT_W-1:0]    tick_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               s1_q, s2_q, prev_q;
    logic [SEL_W-1:0]   tap_q;
    logic [PS_W-1:0]    ps_cnt_q, ps_cnt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               tick_q, tick_d;
    logic               armed_q, armed_d;

    logic               raw_s;
    logic               edge_s;
    logic               tap_chg_s;

    // Tap mux: an index beyond the bus matches no bit, so raw stays 0.
    always_comb begin
        raw_s = 1'b0;
        for (int i = 0; i < N_CLOCKS; i++) begin
            raw_s = (int'(tap_sel) == i) ? divided_clocks[i] : raw_s;
        end
    end

    assign edge_s    = s2_q & ~prev_q;
    assign tap_chg_s = (tap_sel != tap_q);

    // Next-state and output decode; enable beats tap change beats edge.
    always_comb begin
        state_d  = state_q;
        ps_cnt_d = ps_cnt_q;
        cnt_d    = cnt_q;
        tick_d   = 1'b0;
        if (!enable) begin
            state_d  = ST_IDLE;
            ps_cnt_d = {PS_W{1'b0}};
            cnt_d    = {CNT_W{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d  = ST_ARM;
                    ps_cnt_d = {PS_W{1'b0}};
                    cnt_d    = {CNT_W{1'b0}};
                end
                ST_ARM: begin
                    // The first edge after arming has unknown phase: swallow it.
                    ps_cnt_d = {PS_W{1'b0}};
                    if (tap_chg_s) begin
                        state_d = ST_ARM;
                    end else if (edge_s) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_ARM;
                    end
                end
                ST_RUN: begin
                    if (tap_chg_s) begin
                        state_d  = ST_ARM;
                        ps_cnt_d = {PS_W{1'b0}};
                    end else if (edge_s) begin
                        // Exact match only: a postscale lowered below ps_cnt
                        // lets the counter run on and wrap before matching.
                        if (ps_cnt_q == postscale) begin
                            tick_d   = 1'b1;
                            ps_cnt_d = {PS_W{1'b0}};
                            cnt_d    = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                        end else begin
                            ps_cnt_d = ps_cnt_q + {{(PS_W-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    ps_cnt_d = {PS_W{1'b0}};
                    cnt_d    = {CNT_W{1'b0}};
                end
            endcase
        end
        armed_d = (state_d == ST_RUN);
    end

    // Synchronizer, edge history, tap register, FSM and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            prev_q   <= 1'b0;
            tap_q    <= {SEL_W{1'b0}};
            state_q  <= ST_IDLE;
            ps_cnt_q <= {PS_W{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
            tick_q   <= 1'b0;
            armed_q  <= 1'b0;
        end else begin
            s1_q     <= raw_s;
            s2_q     <= s1_q;
            prev_q   <= s2_q;
            tap_q    <= tap_sel;
            state_q  <= state_d;
            ps_cnt_q <= ps_cnt_d;
            cnt_q    <= cnt_d;
            tick_q   <= tick_d;
            armed_q  <= armed_d;
        end
    end

    assign tick       = tick_q;
    assign armed      = armed_q;
    assign tick_count = cnt_q;

endmodule

// File: tb/tb_divclk_tick_gen.sv
// -----------------------------------------------------------------------------
// Testbench for divclk_tick_gen. divided_clocks is a counter advanced on every
// falling clock edge, so bit i rises every 2^(i+1) clocks. Expected ticks
// (cycle, count) are queued when a scenario starts; a monitor pops one entry
// per observed tick. A second instance with a 4-bit tick counter shares all
// inputs so counter wrap is seen within a short run.
// -----------------------------------------------------------------------------
module tb_divclk_tick_gen;

    logic        clock;
    logic        reset_n;
    logic        enable;
    logic [4:0]  tap_sel;
    logic [31:0] dc;
    logic [7:0]  postscale;
    logic        tick, armed;
    logic [15:0] tick_count;
    logic        tick_w4, armed_w4;
    logic [3:0]  tick_count_w4;

    int cyc;
    int n_checks;
    int n_pass;

    typedef struct {
        int cyc;
        int cnt;
    } exp_t;

    exp_t sb_q[$];

    divclk_tick_gen u_dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .enable         (enable),
        .tap_sel        (tap_sel),
        .divided_clocks (dc),
        .postscale      (postscale),
        .tick           (tick),
        .armed          (armed),
        .tick_count     (tick_count)
    );

    divclk_tick_gen #(.CNT_W(4)) u_dut_w4 (
        .clock          (clock),
        .reset_n        (reset_n),
        .enable         (enable),
        .tap_sel        (tap_sel),
        .divided_clocks (dc),
        .postscale      (postscale),
        .tick           (tick_w4),
        .armed          (armed_w4),
        .tick_count     (tick_count_w4)
    );

    // Clock and posedge cycle counter.
    initial begin
        clock = 1'b0;
        cyc   = 0;
        forever begin
            #5 clock = 1'b1;
            cyc = cyc + 1;
            #5 clock = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end else begin
            n_pass = n_pass + 1;
        end
    endtask

    task automatic chk_outs(input string name, input logic t, input logic a, input int c);
        chk({name, "_tick"},  32'(tick),       32'(t));
        chk({name, "_armed"}, 32'(armed),      32'(a));
        chk({name, "_count"}, 32'(tick_count), 32'(c));
    endtask

    task automatic chk_armed(input string name, input logic a);
        chk(name,            32'(armed),    32'(a));
        chk({name, "_w4"},   32'(armed_w4), 32'(a));
    endtask

    task automatic push_tick(input int c, input int n);
        exp_t e;
        e.cyc = c;
        e.cnt = n;
        sb_q.push_back(e);
    endtask

    // Advance to the next falling edge; the divider counter moves there.
    task automatic step();
        @(negedge clock);
        dc = dc + 32'd1;
    endtask

    task automatic goto(input int c);
        while (cyc < c) step();
    endtask

    // Monitor: every tick must match the head of the scoreboard.
    initial begin
        logic prev_tick;
        exp_t e;
        prev_tick = 1'b0;
        forever begin
            @(negedge clock);
            if (tick === 1'b1) begin
                if (sb_q.size() == 0) begin
                    n_checks = n_checks + 1;
                    $display("FAIL unexpected_tick: got tick at cycle %0d, expected none", cyc);
                end else begin
                    e = sb_q.pop_front();
                    chk("tick_cycle",    32'(cyc),           32'(e.cyc));
                    chk("tick_count",    32'(tick_count),    32'(e.cnt));
                    chk("tick_count_w4", 32'(tick_count_w4), 32'(e.cnt & 15));
                    chk("tick_w4",       32'(tick_w4),       32'd1);
                    chk("tick_width",    32'(prev_tick),     32'd0);
                end
            end
            prev_tick = tick;
        end
    end

    // Directed stimulus with hand-derived tick schedules.
    initial begin
        int b;
        int r;
        n_checks  = 0;
        n_pass    = 0;
        reset_n   = 1'b0;
        enable    = 1'b0;
        tap_sel   = 5'd2;
        postscale = 8'd0;
        dc        = 32'd0;

        step();
        step();
        chk_outs("reset", 1'b0, 1'b0, 0);
        reset_n = 1'b1;
        step();
        chk_outs("idle_disabled", 1'b0, 1'b0, 0);

        // Tap 2, postscale 0: bit-2 rises at offsets 5,13,.. -> edge acted on
        // 2 cycles later; the first is swallowed, then ticks every 8 clocks.
        b = cyc;
        enable = 1'b1;
        dc = 32'd0;
        for (int i = 1; i <= 5; i++) push_tick(b + 7 + 8 * i, i);
        goto(b + 6);  chk_armed("s1_arm_wait", 1'b0);
        goto(b + 7);  chk_armed("s1_armed", 1'b1);
        goto(b + 48);

        // Tap 0, postscale 3: swallow at +4, counted edges at +6,+8,+10,+12.
        b = cyc;
        tap_sel = 5'd0;
        postscale = 8'd3;
        dc = 32'd0;
        for (int i = 0; i < 4; i++) push_tick(b + 12 + 8 * i, 6 + i);
        goto(b + 1);  chk_armed("s2_rearm", 1'b0);
        goto(b + 4);  chk_armed("s2_armed", 1'b1);
        goto(b + 37);

        // Tap 1 then tap 3; the switch at +20 coincides with an edge at +21.
        b = cyc;
        tap_sel = 5'd1;
        postscale = 8'd0;
        dc = 32'd0;
        for (int i = 0; i < 3; i++) push_tick(b + 9 + 4 * i, 10 + i);
        for (int i = 0; i < 3; i++) push_tick(b + 43 + 16 * i, 13 + i);
        goto(b + 1);  chk_armed("s3_rearm", 1'b0);
        goto(b + 5);  chk_armed("s3_armed_t1", 1'b1);
        goto(b + 20); tap_sel = 5'd3;
        goto(b + 21); chk_armed("s3_switch_drop", 1'b0);
        goto(b + 26); chk_armed("s3_swallow_wait", 1'b0);
        goto(b + 27); chk_armed("s3_armed_t3", 1'b1);

        // Enable dropped with ps_cnt=2, then re-enabled.
        goto(b + 76);  postscale = 8'd3;
        goto(b + 110); chk("s4_count_before", 32'(tick_count), 32'd15);
        enable = 1'b0;
        goto(b + 111); chk_outs("s4_disabled", 1'b0, 1'b0, 0);
        goto(b + 125); chk_outs("s4_idle", 1'b0, 1'b0, 0);
        goto(b + 130); enable = 1'b1;
        push_tick(b + 203, 1);
        goto(b + 138); chk_armed("s4_swallow_wait", 1'b0);
        goto(b + 139); chk_armed("s4_armed", 1'b1);
        goto(b + 204);

        // Tap 0, postscale 0: tick every 2 clocks; the 4-bit counter wraps.
        b = cyc;
        tap_sel = 5'd0;
        postscale = 8'd0;
        dc = 32'd0;
        for (int i = 0; i < 20; i++) push_tick(b + 6 + 2 * i, 2 + i);
        goto(b + 3);  chk_armed("s5_arm_wait", 1'b0);
        goto(b + 4);  chk_armed("s5_armed", 1'b1);
        goto(b + 45);

        // Asynchronous reset while a tick is high.
        @(posedge clock);
        #1;
        chk("s5_pre_reset_tick", 32'(tick), 32'd1);
        reset_n = 1'b0;
        #1;
        chk_outs("async_reset", 1'b0, 1'b0, 0);
        chk("async_reset_armed_w4", 32'(armed_w4), 32'd0);
        step();
        step();
        step();
        r = cyc;
        chk_outs("reset_held", 1'b0, 1'b0, 0);
        reset_n = 1'b1;
        dc = 32'd0;
        push_tick(r + 6, 1);
        push_tick(r + 8, 2);
        goto(r + 1);  chk_outs("post_reset", 1'b0, 1'b0, 0);
        goto(r + 3);  chk_armed("post_reset_wait", 1'b0);
        goto(r + 4);  chk_armed("post_reset_armed", 1'b1);

        // Tap 31 never sees an edge; the coincident tap-0 edge is dropped.
        goto(r + 9);   tap_sel = 5'd31;
        goto(r + 10);  chk_armed("tap31_arm", 1'b0);
        goto(r + 100); chk_outs("tap31_stuck", 1'b0, 1'b0, 2);
        goto(r + 120);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/divclk_tick_gen.md
Name: divclk_tick_gen

Overview:
- Consumer end of the divided-clock bus produced by the clock divider. Selects one tap of `divided_clocks` and samples it in the fast `clock` domain.
- Converts rising edges on that tap into single-cycle `tick` strobes, with an optional postscaler and a running tick counter.
- Game timing logic uses `tick` as a clock enable, so no logic is clocked from a divided clock directly.

Parameters:
- N_CLOCKS, 32, width of the `divided_clocks` input bus
- SEL_W, 5, width of `tap_sel`
- PS_W, 8, width of `postscale`
- CNT_W, 16, width of `tick_count`

Ports:
- clock  input  1  system clock; all logic on its rising edge
- reset_n  input  1  asynchronous, active-low reset
- enable  input  1  1 = generate ticks; 0 = force IDLE
- tap_sel  input  SEL_W  index of the `divided_clocks` bit to follow
- divided_clocks  input  N_CLOCKS  divided-clock bus from the clock divider
- postscale  input  PS_W  emit a tick every (postscale+1) tap rising edges
- tick  output  1  one-clock strobe
- armed  output  1  1 while in RUN state
- tick_count  output  CNT_W  number of ticks since reset or since leaving IDLE; wraps

Behaviour:
- Reset (reset_n=0, asynchronous): all of the following clear to 0 and state=IDLE:
  - `tick`, `armed`, `tick_count`
  - sync flops, edge-history flop
  - postscale counter `ps_cnt`, registered `tap_q`
- Tap mux: `raw = divided_clocks[tap_sel]`. If `tap_sel >= N_CLOCKS`, `raw=0` and no edges are ever seen.
- Synchronizer: 2 flops, `s1 <= raw`, `s2 <= s1`. History flop `prev <= s2`.
- Edge detect: `edge = s2 & ~prev` (combinational).
- `tap_q <= tap_sel` every cycle. `tap_chg = (tap_sel != tap_q)`.
- State machine:
  - IDLE
    - `tick=0`, `armed=0`, `ps_cnt` held at 0, `tick_count` held at 0.
    - `enable=1` -> ARM.
  - ARM
    - `armed=0`. Waits for the first `edge`. That edge is swallowed (no tick), since its phase relative to enable or tap change is unknown.
    - On `edge` -> RUN with `ps_cnt=0`.
    - `tap_chg` -> stay ARM.
  - RUN
    - `armed=1`.
    - On `edge` with `ps_cnt==postscale`: `tick<=1`, `ps_cnt<=0`, `tick_count<=tick_count+1` (mod 2^CNT_W).
    - On `edge` otherwise: `ps_cnt<=ps_cnt+1`.
    - `tap_chg` -> ARM and `ps_cnt<=0`.
  - Any state, `enable=0` -> IDLE on the next edge of `clock`. `tick` is forced 0 in that cycle; `tick_count` clears on entering IDLE.
- Priority (highest first): `enable=0` > `tap_chg` > `edge`. An edge coinciding with a tap change produces no tick.
- `tick` is registered and high for exactly one cycle. It is never high in consecutive cycles, because tap 0 toggles at most every cycle and the edge detector needs a 0->1 pair.
- Latency: if `raw` rises before posedge k:
  - `s1=1` after k, `s2=1` after k+1, `edge` is true during cycle k+1..k+2.
  - `tick` is high from posedge k+2 to posedge k+3.
  - Fixed 3-cycle latency.
- `postscale` may change at any time. It takes effect at the next compare. If the new value is below the current `ps_cnt`, the counter continues up and wraps at 2^PS_W before matching. This is defined behaviour, not an error.
- `postscale=0`: every qualifying edge ticks.
- Reset asserted mid-RUN: immediate return to reset values. After release, the block waits in IDLE or ARM as above, and a swallowed edge always precedes the first tick.

Test Plan:
- Setup for all scenarios: the bench drives `divided_clocks` from a 32-bit counter incremented each `clock`, so bit i rises every 2^(i+1) clocks.
- tap_sel=2, postscale=0, enable=1 at cycle 0 -> first bit-2 edge swallowed (`armed` rises), then `tick` pulses every 8 clocks; `tick_count`=5 after 5 pulses; every pulse is exactly 1 cycle wide.
- tap_sel=0, postscale=3 -> tick every 8 clocks (4 edges x 2 clocks); `tick_count` increments by 1 per tick; check the 3-cycle latency from the 4th counted `raw` rise to `tick`.
- In RUN on tap 1, switch tap_sel to 3 -> `armed` drops next cycle, no tick on the first bit-3 edge, then ticks every 16 clocks; an edge arriving in the same cycle as the switch produces no tick.
- enable dropped mid-RUN with `ps_cnt`=2 -> `tick`=0 and `tick_count`=0 next cycle, no ticks while low; re-enable -> ARM, swallowed edge, count restarts from 1.
- Preload `tick_count`=16'hFFFF by running 65535 ticks at tap 0, postscale=0 -> next tick gives 16'h0000; reset_n pulsed low mid-RUN -> all outputs 0 asynchronously, IDLE after release.
- tap_sel=31 with counter bit 31 held 0 -> stays in ARM indefinitely, `tick` never asserts, `armed`=0.
